// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and freeze.
// Optional stall counter port StallCnt_o is built when IF_ID_STALL_CNT_EN is defined.
module if_id_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] PC_i,
  input  logic [31:0] Instr_i,
  input  logic        Flush_i,
  input  logic        Freeze_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RDaddr_i,
  output logic [31:0] PC_o,
  output logic [31:0] Instr_o,
  output logic        Valid_o,
  output logic        PCWrite_o,
  output logic        NoOp_o
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0] StallCnt_o
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_instr_nxt;
  logic            w_valid;
  logic            w_hazard;

  assign w_valid = (r_state == ST_FULL);

  // Load in ID/EX whose destination feeds rs1 or rs2 of the instruction in ID.
  assign w_hazard = w_valid & IDEX_MemRead_i & (IDEX_RDaddr_i != 5'd0) &
                    ((IDEX_RDaddr_i == r_instr[19:15]) | (IDEX_RDaddr_i == r_instr[24:20]));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  // Freeze beats hazard beats flush; a stalled branch must wait for its operands.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    if (Freeze_i || w_hazard) begin
      w_state_nxt = r_state;
    end else if (Flush_i) begin
      w_state_nxt = ST_EMPTY;
      w_pc_nxt    = PC_i;
      w_instr_nxt = NOP_INSTR;
    end else begin
      w_state_nxt = ST_FULL;
      w_pc_nxt    = PC_i;
      w_instr_nxt = Instr_i;
    end
  end

  always_comb begin
    PC_o      = r_pc;
    Instr_o   = r_instr;
    Valid_o   = w_valid;
    NoOp_o    = w_hazard;
    PCWrite_o = ~w_hazard & ~Freeze_i;
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [XLEN-1:0] r_stall_cnt;

  // Saturating count of load-use stall edges that actually took effect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !Freeze_i && (r_stall_cnt != {XLEN{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + XLEN'(1);
    end
  end

  assign StallCnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed scoreboard bench for if_id_stage; works with or without IF_ID_STALL_CNT_EN.
module tb_if_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        flush;
  logic        freeze;
  logic        memread;
  logic [4:0]  rdaddr;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        pcwrite_o;
  logic        noop_o;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stallcnt_o;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  exp_t sb_q[$];

  if_id_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .PC_i           (pc_i),
    .Instr_i        (instr_i),
    .Flush_i        (flush),
    .Freeze_i       (freeze),
    .IDEX_MemRead_i (memread),
    .IDEX_RDaddr_i  (rdaddr),
    .PC_o           (pc_o),
    .Instr_o        (instr_o),
    .Valid_o        (valid_o),
    .PCWrite_o      (pcwrite_o),
    .NoOp_o         (noop_o)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .StallCnt_o     (stallcnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag, input logic noop_e, input logic pcw_e);
    chk({tag, "_noop"}, 32'(noop_o), 32'(noop_e));
    chk({tag, "_pcwrite"}, 32'(pcwrite_o), 32'(pcw_e));
  endtask

  task automatic chk_cnt(input string tag);
`ifdef IF_ID_STALL_CNT_EN
    chk({tag, "_cnt"}, stallcnt_o, 32'(exp_cnt));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic v);
    exp_t e;
    e.pc = p; e.instr = i; e.valid = v;
    sb_q.push_back(e);
  endtask

  // One clock edge, then compare registered outputs against the oldest expectation.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    n_tests++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_pc"}, pc_o, e.pc);
      chk({tag, "_instr"}, instr_o, e.instr);
      chk({tag, "_valid"}, 32'(valid_o), 32'(e.valid));
    end
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; instr_i = '0; flush = 1'b0; freeze = 1'b0;
    memread = 1'b0; rdaddr = '0;
    #12;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", instr_o, 32'h13);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk_comb("rst", 1'b0, 1'b1);
    chk_cnt("rst");
    #3 rst = 1'b0;

    // normal load
    pc_i = 32'h10; instr_i = 32'h00A00093;
    push(32'h10, 32'h00A00093, 1'b1);
    tick("load1");
    chk_comb("load1", 1'b0, 1'b1);

    pc_i = 32'h14; instr_i = 32'h002081B3;
    push(32'h14, 32'h002081B3, 1'b1);
    tick("load2");

    // load-use stall on rs2
    memread = 1'b1; rdaddr = 5'd2; pc_i = 32'h18; instr_i = 32'h00310233;
    #1 chk_comb("stall", 1'b1, 1'b0);
    push(32'h14, 32'h002081B3, 1'b1);
    exp_cnt++;
    tick("stall");
    memread = 1'b0;
    #1 chk_comb("bubble", 1'b0, 1'b1);
    chk_cnt("stall");

    // rd = x0 never hazards
    memread = 1'b1; rdaddr = 5'd0;
    #1 chk_comb("rdx0", 1'b0, 1'b1);
    push(32'h18, 32'h00310233, 1'b1);
    tick("rdx0");

    // flush with concurrent hazard on rs2=3 is ignored
    rdaddr = 5'd3; flush = 1'b1; pc_i = 32'h1C; instr_i = 32'h00000000;
    #1 chk_comb("flushhaz", 1'b1, 1'b0);
    push(32'h18, 32'h00310233, 1'b1);
    exp_cnt++;
    tick("flushhaz");

    // flush without hazard
    memread = 1'b0;
    push(32'h1C, 32'h13, 1'b0);
    tick("flush");
    chk_comb("flush", 1'b0, 1'b1);

    flush = 1'b0; pc_i = 32'h20; instr_i = 32'h00A00093;
    push(32'h20, 32'h00A00093, 1'b1);
    tick("load3");

    // freeze for 3 edges; hazard during freeze must not count
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc_i = 32'h24 + 32'(4 * k);
      instr_i = 32'hDEAD0000 + 32'(k);
      if (k == 2) begin
        memread = 1'b1; rdaddr = 5'd10;
      end
      #1 chk_comb("freeze", (k == 2), 1'b0);
      push(32'h20, 32'h00A00093, 1'b1);
      tick("freeze");
    end
    chk_cnt("freeze");

    // stall, then asynchronous reset mid-stall
    freeze = 1'b0;
    push(32'h20, 32'h00A00093, 1'b1);
    exp_cnt++;
    tick("stall2");
    chk_cnt("stall2");
    chk_comb("stall2", 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_instr", instr_o, 32'h13);
    chk("arst_valid", 32'(valid_o), 32'h0);
    chk_comb("arst", 1'b0, 1'b1);
    chk_cnt("arst");
    #1 rst = 1'b0;

    // first post-reset edge loads normally despite memread still high
    pc_i = 32'h24; instr_i = 32'h002081B3; rdaddr = 5'd2;
    push(32'h24, 32'h002081B3, 1'b1);
    tick("postrst");
    chk_comb("postrst", 1'b1, 1'b0);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port `clk_i`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst_i`, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port `PC_i`, input, 32 bits: PC of the fetched instruction.
REQ-004 SHALL have port `Instr_i`, input, 32 bits: fetched instruction word.
REQ-005 SHALL have port `Flush_i`, input, 1 bit: taken branch resolved in ID; discard the fetched instruction.
REQ-006 SHALL have port `Freeze_i`, input, 1 bit: external pipeline freeze; hold all state.
REQ-007 SHALL have port `IDEX_MemRead_i`, input, 1 bit: MemRead of the instruction currently in the ID/EX register.
REQ-008 SHALL have port `IDEX_RDaddr_i`, input, 5 bits: destination register of the instruction in ID/EX.
REQ-009 SHALL have port `PC_o`, output, 32 bits: registered PC.
REQ-010 SHALL have port `Instr_o`, output, 32 bits: registered instruction.
REQ-011 SHALL have port `Valid_o`, output, 1 bit: `Instr_o` holds a real instruction.
REQ-012 SHALL have port `PCWrite_o`, output, 1 bit: PC register update enable.
REQ-013 SHALL have port `NoOp_o`, output, 1 bit: force all ID control signals to 0 (bubble into ID/EX).
REQ-014 SHALL have port `StallCnt_o`, output, 32 bits: load-use stall counter (present only per REQ-030).

Function
REQ-015 SHALL compute `hazard` combinationally = `Valid_o` & `IDEX_MemRead_i` & (`IDEX_RDaddr_i` != 0) & (`IDEX_RDaddr_i` == `Instr_o`[19:15] | `IDEX_RDaddr_i` == `Instr_o`[24:20]).
REQ-016 SHALL drive `NoOp_o` = `hazard`, and `PCWrite_o` = !`hazard` & !`Freeze_i`.
REQ-017 SHALL use a 2-state FSM: EMPTY (`Valid_o`=0) and FULL (`Valid_o`=1).
REQ-018 SHALL apply per-edge priority, highest first: `Freeze_i`, then `hazard`, then `Flush_i`, then normal load.
REQ-019 SHALL, when `Freeze_i`=1, hold `PC_o`, `Instr_o`, `Valid_o` and the FSM state.
REQ-020 SHALL, on hazard (no freeze), hold `PC_o`, `Instr_o`, `Valid_o`; ignore `Flush_i` that cycle (branch operands not yet valid).
REQ-021 SHALL, on `Flush_i` (no freeze, no hazard), load `Instr_o` = 32'h00000013 (NOP), `PC_o` = `PC_i`, `Valid_o` = 0; next state EMPTY.
REQ-022 SHALL, otherwise, load `PC_o` = `PC_i`, `Instr_o` = `Instr_i`, `Valid_o` = 1; next state FULL.
REQ-023 SHALL limit a load-use hazard to exactly one stall cycle per load: after the stall edge, the load leaves ID/EX, so `IDEX_MemRead_i` is 0 for the bubble.
REQ-024 SHALL NOT raise a hazard in EMPTY state, nor when rd=x0.
REQ-025 SHALL add no latency: data captured on edge N is visible on outputs after edge N.

Reset
REQ-026 SHALL, on `rst_i`=1 (asynchronous, regardless of clock), set `PC_o`=0, `Instr_o`=32'h00000013, `Valid_o`=0, FSM=EMPTY, and the stall counter to 0.
REQ-027 SHALL drive `PCWrite_o`=1 (unless `Freeze_i`) and `NoOp_o`=0 during and immediately after reset.
REQ-028 SHALL, when reset asserts mid-stall, abort the stall at once; the first post-reset edge loads `Instr_i` normally.

Configuration
REQ-029 SHALL use macro `IF_ID_STALL_CNT_EN`.
REQ-030 SHALL, when `IF_ID_STALL_CNT_EN` is defined, provide `StallCnt_o`: increments by 1 on each edge where `hazard`=1 and `Freeze_i`=0, and saturates at 32'hFFFFFFFF.
REQ-031 SHALL, when `IF_ID_STALL_CNT_EN` is undefined, omit the `StallCnt_o` port and counter logic; all other behaviour identical.

Verification
REQ-032 SHALL test normal load: `PC_i`=0x10, `Instr_i`=0x00A00093, one edge -> `PC_o`=0x10, `Instr_o`=0x00A00093, `Valid_o`=1, `PCWrite_o`=1.
REQ-033 SHALL test a load-use stall: `Instr_o`=0x002081B3 (rs1=1, rs2=2), `IDEX_MemRead_i`=1, `IDEX_RDaddr_i`=2 -> `NoOp_o`=1, `PCWrite_o`=0, outputs held one edge; next cycle with `IDEX_MemRead_i`=0 -> `NoOp_o`=0; counter=1 when macro is on.
REQ-034 SHALL test rd=x0: `IDEX_MemRead_i`=1, `IDEX_RDaddr_i`=0 -> `NoOp_o`=0.
REQ-035 SHALL test flush: `Flush_i`=1, no hazard -> `Instr_o`=0x00000013, `Valid_o`=0; with a simultaneous hazard -> `Flush_i` ignored, outputs held.
REQ-036 SHALL test freeze: `Freeze_i`=1 for 3 edges with changing `PC_i` -> outputs unchanged, `PCWrite_o`=0.
REQ-037 SHALL test async reset: `rst_i` pulsed between edges during a stall -> outputs reset immediately per REQ-026; counter=0.
